fig1_1_pipe: RTL and testbench

Parametrised, pipelined successor to the Fig 1.1 gate circuit. It evaluates X = NOR((B XOR C) AND A, NOT A), which equals A AND NOT(B XOR C), bitwise across WIDTH independent lanes. Operands move through a two-stage valid/ready pipeline with backpressure. A built-in exhaustive-sweep mode drives all eight ABC patterns through the same pipeline and reports the population count of the results, giving a self-check in place of a bench-driven truth-table walk.

---
 rtl/fig1_1_pipe.sv | 124 ++++++++++++
 tb/tb_fig1_1_pipe.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fig1_1_pipe.sv
// fig1_1_pipe: computes X = NOR((B ^ C) & A, ~A) on WIDTH lanes through a two-stage
// valid/ready pipeline. A built-in sweep mode pushes all eight broadcast ABC
// patterns through the same stages and totals the ones in the results.
module fig1_1_pipe #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = $clog2(8 * WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] X,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] ones_count
);

  typedef enum logic [1:0] {StIdle, StSweep, StDrain, StDone} state_e;

  state_e           state, state_next;
  logic             s1_v, s2_v;
  logic [WIDTH-1:0] w1, w2, a1;
  logic [2:0]       pat;
  logic             s1_adv, s2_adv, start_go, load_s1;
  logic [WIDTH-1:0] a_in, b_in, c_in;
  logic [CNT_W-1:0] x_ones;

  // Handshake, stage advance and stage-1 operand selection.
  always_comb begin
    // Sweep results are consumed internally, so stage 2 never stalls outside IDLE.
    s2_adv    = !s2_v || out_ready || (state != StIdle);
    s1_adv    = !s1_v || s2_adv;
    start_go  = (state == StIdle) && start && !s1_v && !s2_v;
    // An honoured start owns the pipeline; no stream operand may slip in beside it.
    in_ready  = (state == StIdle) && s1_adv && !start_go;
    out_valid = s2_v && (state == StIdle);
    busy      = (state != StIdle);
    done      = (state == StDone);
    if (state == StSweep) begin
      a_in = {WIDTH{pat[2]}};
      b_in = {WIDTH{pat[1]}};
      c_in = {WIDTH{pat[0]}};
    end else begin
      a_in = A;
      b_in = B;
      c_in = C;
    end
    load_s1 = (state == StSweep) || (in_valid && in_ready);
  end

  // Population count of the stage-2 result.
  always_comb begin
    x_ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      x_ones = x_ones + CNT_W'(X[i]);
    end
  end

  // Sweep controller next-state.
  always_comb begin
    state_next = state;
    unique case (state)
      StIdle:  if (start_go) state_next = StSweep;
      StSweep: if (pat == 3'd7) state_next = StDrain;
      // Once stage 1 is empty, this edge retires the last stage-2 result.
      StDrain: if (!s1_v) state_next = StDone;
      StDone:  state_next = StIdle;
      default: state_next = StIdle;
    endcase
  end

  // Controller state, pattern counter and ones accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      pat        <= 3'd0;
      ones_count <= '0;
    end else begin
      state <= state_next;
      if (start_go) begin
        pat        <= 3'd0;
        ones_count <= '0;
      end else begin
        if (state == StSweep) pat <= pat + 3'd1;
        if (busy && s2_v) ones_count <= ones_count + x_ones;
      end
    end
  end

  // Stage 1: partial terms w1 = B^C, w2 = ~A and a copy of A.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      w1   <= '0;
      w2   <= '0;
      a1   <= '0;
    end else if (s1_adv) begin
      s1_v <= load_s1;
      if (load_s1) begin
        w1 <= b_in ^ c_in;
        w2 <= ~a_in;
        a1 <= a_in;
      end
    end
  end

  // Stage 2: final NOR into X.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v <= 1'b0;
      X    <= '0;
    end else if (s2_adv) begin
      s2_v <= s1_v;
      if (s1_v) X <= ~((w1 & a1) | w2);
    end
  end

endmodule

// File: tb/tb_fig1_1_pipe.sv
// Bench for fig1_1_pipe: accepted operands push expected results into a queue,
// an independent monitor pops and compares whenever the DUT emits.
module tb_fig1_1_pipe;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = $clog2(8 * W + 1);

  logic          clk, rst;
  logic [W-1:0]  a, b, c, x;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic          start, busy, done;
  logic [CW-1:0] ones_count;

  fig1_1_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .A(a), .B(b), .C(c),
    .in_valid(in_valid), .in_ready(in_ready),
    .X(x), .out_valid(out_valid), .out_ready(out_ready),
    .start(start), .busy(busy), .done(done), .ones_count(ones_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] x;
    int           cyc;
    bit           lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   lat_chk = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: a lane is 1 exactly when A is 1 and B equals C.
  function automatic logic [W-1:0] model(input logic [W-1:0] av, bv, cv);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = (av[i] == 1'b1) && (bv[i] == cv[i]);
    return r;
  endfunction

  // Scoreboard producer: an operand is taken at the next edge.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) sb.push_back('{x: model(a, b, c), cyc: cyc, lat: lat_chk});
  end

  // Monitor: compare emitted results, and hold stability while stalled.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else if (out_ready) begin
        e = sb.pop_front();
        chk("x_result", x, e.x);
        if (e.lat) chk("latency", cyc - e.cyc, 2);
      end else begin
        chk("stall_x_stable", x, sb[0].x);
      end
    end
  end

  task automatic send(input logic [W-1:0] av, bv, cv);
    bit ok = 0;
    int t = 0;
    a = av; b = bv; c = cv; in_valid = 1'b1;
    while (!ok && t < 20) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      t++;
    end
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int t = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    while (sb.size() != 0 && t < 30) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_empty", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic rand_stream(input int n);
    lat_chk = 0;
    repeat (n) begin
      a = W'($urandom); b = W'($urandom); c = W'($urandom);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  logic [W-1:0] bp_a[3], bp_b[3], bp_c[3];
  int           exp_ones;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int acc, idx;
    bit got;
    logic [W-1:0] bc;

    // Reset with random inputs.
    rst = 1'b1; start = 1'b0;
    a = W'($urandom); b = W'($urandom); c = W'($urandom);
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_x", x, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ones", ones_count, 0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Broadcast truth table, back-to-back.
    out_ready = 1'b1; lat_chk = 1;
    for (int p = 0; p < 8; p++) begin
      send({W{p[2]}}, {W{p[1]}}, {W{p[0]}});
    end
    in_valid = 1'b0;
    drain();

    // Mixed lanes.
    send(4'b1111, 4'b1100, 4'b1010);
    send(4'b0101, 4'b0011, 4'b0011);
    in_valid = 1'b0; lat_chk = 0;
    drain();

    // Backpressure: three items offered with out_ready low.
    for (int i = 0; i < 3; i++) begin
      bp_a[i] = W'($urandom); bp_b[i] = W'($urandom); bp_c[i] = W'($urandom);
    end
    out_ready = 1'b0; acc = 0; idx = 0;
    a = bp_a[0]; b = bp_b[0]; c = bp_c[0]; in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk); #1;
      if (got) begin
        acc++; idx++;
        if (idx < 3) begin a = bp_a[idx]; b = bp_b[idx]; c = bp_c[idx]; end
      end
    end
    @(negedge clk);
    chk("bp_accepted", acc, 2);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_full_pass_through", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    rand_stream(60);
    drain();

    // Sweep with external inputs toggling; none of it may leak in or out.
    exp_ones = 0;
    for (int p = 0; p < 8; p++) begin
      bc = model({W{p[2]}}, {W{p[1]}}, {W{p[0]}});
      exp_ones += $countones(bc);
    end
    in_valid = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      chk("sweep_busy", busy, 1);
      chk("sweep_in_ready", in_ready, 0);
      chk("sweep_out_valid", out_valid, 0);
      chk("sweep_done", done, (k == 10));
      if (k == 10) chk("sweep_ones", ones_count, exp_ones);
      @(posedge clk); #1;
      a = W'($urandom); b = W'($urandom); c = W'($urandom);
      in_valid = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("sweep_end_busy", busy, 0);
    chk("sweep_end_done", done, 0);
    chk("sweep_hold_ones", ones_count, exp_ones);
    @(posedge clk); #1;
    drain();

    // Start while a result is waiting must be ignored.
    out_ready = 1'b0;
    send(W'($urandom), W'($urandom), W'($urandom));
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("start_ignored_busy", busy, 0);
    chk("start_ignored_out_valid", out_valid, 1);
    @(posedge clk); #1;
    drain();

    // Reset in the middle of a sweep, after some ones have accumulated.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_ones", ones_count, 0);
    chk("midrst_done", done, 0);
    chk("midrst_in_ready", in_ready, 1);
    repeat (12) begin
      @(negedge clk);
      chk("midrst_no_done", done, 0);
    end
    @(posedge clk); #1;
    rand_stream(40);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
